// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the renderer's board placement.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_CW      = 10;

    // Top-left pixel of the minesweeper board inside the visible area.
    localparam int BOARD_X0 = 160;
    localparam int BOARD_Y0 = 80;

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N raster counter with terminal-count flag and a registered sync window.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int N           = DEF_H_TOTAL,
    parameter int WIN_START   = DEF_H_VISIBLE + DEF_H_FP,
    parameter int WIN_END     = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic          mclk,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] nxt,
    output logic          wrap,
    output logic          sync
);

    assign wrap = (cnt == CW'(N - 1));

    // nxt equals cnt when idle, so the sync register simply tracks it every cycle.
    always_comb begin
        nxt = cnt;
        if (en)
            nxt = wrap ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            cnt  <= '0;
            sync <= ~SYNC_ACTIVE;
        end else begin
            cnt  <= nxt;
            sync <= (nxt >= CW'(WIN_START) && nxt < CW'(WIN_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters advance on pix_en, decode registered from next counts.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int CW          = DEF_CW
) (
    input  logic          mclk,
    input  logic          clr,
    input  logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] h_nxt, v_nxt;
    logic          h_wrap, v_wrap;
    logic          v_en;

    assign v_en = pix_en & h_wrap;

    vga_axis_counter #(
        .CW(CW), .N(H_TOTAL),
        .WIN_START(H_VISIBLE + H_FP), .WIN_END(H_VISIBLE + H_FP + H_SYNC),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_h (
        .mclk(mclk), .clr(clr), .en(pix_en),
        .cnt(hcount), .nxt(h_nxt), .wrap(h_wrap), .sync(hsync)
    );

    vga_axis_counter #(
        .CW(CW), .N(V_TOTAL),
        .WIN_START(V_VISIBLE + V_FP), .WIN_END(V_VISIBLE + V_FP + V_SYNC),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_v (
        .mclk(mclk), .clr(clr), .en(v_en),
        .cnt(vcount), .nxt(v_nxt), .wrap(v_wrap), .sync(vsync)
    );

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= (h_nxt < CW'(H_VISIBLE)) && (v_nxt < CW'(V_VISIBLE));
            line_start  <= v_en;
            frame_start <= v_en & v_wrap;
        end
    end

endmodule
